jt10_adpcm_gctl: RTL

JT10_ADPCM_GCTL -- requirements
Module: jt10_adpcm_gctl

---
 rtl/jt10_adpcm_gctl.sv | 80 ++++++++
 1 files changed

// File: rtl/jt10_adpcm_gctl.sv
// ADPCM-A gain control front end: one-hot slot rotation, queued L/R+level writes
// applied in their channel's slot, round-aligned total level, and sample-injection strobes.
module jt10_adpcm_gctl (
  input  logic       rst_n,
  input  logic       clk,
  input  logic       cen,
  input  logic       wr_lr,
  input  logic [2:0] wr_ch,
  input  logic [7:0] wr_din,
  input  logic       wr_atl,
  input  logic [5:0] atl_din,
  input  logic [5:0] dec_req,
  output logic [5:0] cur_ch,
  output logic [2:0] up_ch,
  output logic [7:0] lracl,
  output logic [5:0] atl,
  output logic       match,
  output logic       full,
  output logic       drop
);

  logic [5:0]  nxt;
  logic [10:0] mem [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  cnt;
  logic [10:0] head;
  logic [5:0]  head_oh;
  logic [5:0]  shadow;
  logic [5:0]  pending;
  logic        push, pop;

  assign nxt     = {cur_ch[4:0], cur_ch[5]};
  assign full    = cnt[2];
  assign head    = mem[rd_ptr];
  assign head_oh = 6'd1 << head[10:8];
  assign push    = wr_lr && (wr_ch <= 3'd5) && !full;
  // Pop only from the pre-edge contents, so a same-clk push is never served on that edge
  assign pop     = cen && (cnt != 3'd0) && (head_oh == nxt);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_ch, wr_din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch  <= 6'b000001;
      up_ch   <= 3'd7;
      lracl   <= 8'd0;
      atl     <= 6'd0;
      shadow  <= 6'd0;
      match   <= 1'b0;
      pending <= 6'd0;
      rd_ptr  <= 2'd0;
      wr_ptr  <= 2'd0;
      cnt     <= 3'd0;
      drop    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      cnt <= cnt + {2'b0, push} - {2'b0, pop};
      if (wr_lr && !push) drop <= 1'b1;
      if (wr_atl) shadow <= atl_din;
      // a request on the clearing edge wins and waits for the next round
      if (cen) pending <= (pending & ~nxt) | dec_req;
      else     pending <= pending | dec_req;
      if (cen) begin
        cur_ch <= nxt;
        match  <= |(pending & nxt);
        if (nxt == 6'b000001) atl <= shadow;
        if (pop) begin
          up_ch <= head[10:8];
          lracl <= head[7:0];
        end else begin
          up_ch <= 3'd7;
        end
      end
    end
  end

endmodule
